// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Drains a show-ahead FIFO in fixed-length bursts of BURST_LEN samples.
//   A burst starts only when enough words are already queued, so once a
//   burst begins it never waits on the upstream writer unless the FIFO
//   drops fifo_valid. The registered output is presented on a
//   valid/ready stream, and m_last flags the final beat of each burst.
//
// Ports
//   clk          : sole clock, rising edge
//   reset        : asynchronous, active-high
//   enable       : permits new bursts to start (sampled only in IDLE)
//   fifo_data    : FIFO head word (show-ahead), valid when fifo_valid=1
//   fifo_valid   : FIFO non-empty
//   fifo_count   : FIFO occupancy, unsigned
//   fifo_rd_en   : pops the FIFO head this cycle (combinational)
//   m_data       : registered output sample
//   m_valid      : m_data holds a sample
//   m_last       : final sample of a burst, qualified by m_valid
//   m_ready      : downstream accepts
//   busy         : high while the FSM is in BURST
//   burst_count  : completed bursts (last beat popped), wraps at 16 bits
//   dbg_state    : FSM state (0 = IDLE, 1 = BURST)
//
// Handshake: a beat transfers on a rising edge where m_valid and m_ready
// are both 1. Once m_valid is 1, m_data and m_last stay unchanged until
// that transfer; m_valid never drops without a transfer, and a new pop
// may replace the beat in the same cycle it transfers.

module fifo_burst_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 6,
  parameter int BURST_LEN   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_valid,
  input  logic [COUNT_WIDTH-1:0] fifo_count,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [15:0]            burst_count,
  output logic                   dbg_state
);

  // Beat counter only needs to hold 0..BURST_LEN-1.
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [31:0]       BURST_LEN_U = 32'(BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic [15:0]             burst_count_q, burst_count_d;

  logic [31:0] count_ext;
  logic        start;
  logic        pop;
  logic        xfer;
  logic        last_beat;

  // Zero-extend the occupancy so the threshold compare is unsigned at full
  // width regardless of COUNT_WIDTH.
  assign count_ext = 32'(fifo_count);
  assign start     = enable && (count_ext >= BURST_LEN_U);

  // Pop only when the output register is empty or being emptied this cycle.
  assign pop       = (state_q == BURST) && fifo_valid && (!m_valid_q || m_ready);
  assign xfer      = m_valid_q && m_ready;
  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    burst_count_d = burst_count_q;

    case (state_q)
      IDLE: begin
        // No pop in the transition cycle; the first pop follows one cycle later.
        if (start) begin
          state_d = BURST;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (pop) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            state_d       = IDLE;
            burst_count_d = burst_count_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register: a pop loads a fresh beat (even if the old one is
    // transferring this cycle); a bare transfer empties it.
    if (pop) begin
      m_data_d  = fifo_data;
      m_valid_d = 1'b1;
      m_last_d  = last_beat;
    end else if (xfer) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      burst_count_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      burst_count_q <= burst_count_d;
    end
  end

  assign fifo_rd_en  = pop;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign busy        = (state_q == BURST);
  assign burst_count = burst_count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width, equal to the FIFO data width.
REQ-002 SHALL have parameter COUNT_WIDTH, default 6, width of the FIFO occupancy count (30-deep FIFO).
REQ-003 SHALL have parameter BURST_LEN, default 8, samples per burst; legal range 1..30.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits new bursts to start.
REQ-007 SHALL have port fifo_data  input  DATA_WIDTH  show-ahead FIFO head word, valid when fifo_valid=1.
REQ-008 SHALL have port fifo_valid  input  1  FIFO non-empty.
REQ-009 SHALL have port fifo_count  input  COUNT_WIDTH  FIFO occupancy, unsigned.
REQ-010 SHALL have port fifo_rd_en  output  1  pops the FIFO head this cycle.
REQ-011 SHALL have port m_data  output  DATA_WIDTH  registered output sample.
REQ-012 SHALL have port m_valid  output  1  m_data holds a sample.
REQ-013 SHALL have port m_last  output  1  marks the final sample of a burst; qualified by m_valid.
REQ-014 SHALL have port m_ready  input  1  downstream accepts; a transfer occurs when m_valid and m_ready are both 1.
REQ-015 SHALL have port busy  output  1  high while state is BURST.
REQ-016 SHALL have port burst_count  output  16  number of completed bursts (last beat popped), wraps at 65535 -> 0.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and BURST.
REQ-018 IDLE -> BURST SHALL occur when enable=1 and fifo_count >= BURST_LEN; the beat counter is cleared to 0 on this transition.
REQ-019 No pop SHALL occur in the IDLE state or in the cycle of the IDLE -> BURST transition; the first pop occurs no earlier than the following cycle.
REQ-020 fifo_rd_en SHALL equal (state==BURST) and fifo_valid and (!m_valid or m_ready), combinationally.
REQ-021 On each pop, fifo_data SHALL be registered into m_data, m_valid SHALL be set, and the beat counter SHALL increment; latency from pop to m_valid is 1 cycle.
REQ-022 m_last SHALL be registered as 1 with the pop where beat counter == BURST_LEN-1, and as 0 with every other pop.
REQ-023 On the pop with beat counter == BURST_LEN-1, the FSM SHALL return to IDLE and burst_count SHALL increment.
REQ-024 A transfer without a simultaneous pop SHALL clear m_valid; a simultaneous transfer and pop SHALL keep m_valid=1 with the new data, giving a sustained throughput of 1 sample/cycle.
REQ-025 While m_valid=1 and m_ready=0, m_data and m_last SHALL remain stable and no pop SHALL occur.
REQ-026 If fifo_valid=0 mid-burst, the block SHALL stall without popping or changing the beat counter, then resume when fifo_valid returns to 1.
REQ-027 Deasserting enable mid-burst SHALL NOT abort the burst; enable is sampled only in IDLE.
REQ-028 When BURST_LEN=1, every burst SHALL be a single beat with m_last=1.
REQ-029 A new burst MAY start while the previous last beat is still held in m_data; that beat is delivered first, and the first pop of the new burst occurs only per REQ-020.
REQ-030 fifo_count SHALL be compared as unsigned at full COUNT_WIDTH, with no truncation.

Reset
REQ-031 Asserting reset SHALL immediately force: state=IDLE, beat counter=0, m_valid=0, m_last=0, m_data=0, burst_count=0, and fifo_rd_en=0.
REQ-032 A reset asserted mid-burst SHALL discard the partial burst; popped samples are not replayed and burst_count is not incremented.
REQ-033 After reset deasserts, the first burst SHALL require the condition of REQ-018 to be met anew.

Verification
REQ-034 Bench SHALL cover: FIFO preloaded with 8 words 0x0001..0x0008, enable=1, m_ready=1 -> 8 consecutive beats 0x0001..0x0008, m_last on 0x0008 only, burst_count=1.
REQ-035 Bench SHALL cover: fifo_count=7, enable=1 -> no fifo_rd_en and busy=0 indefinitely; writing an 8th word -> burst begins the next cycle.
REQ-036 Bench SHALL cover: m_ready toggling 1,0,0,1 during a burst -> m_data held stable while m_ready=0, no lost or duplicated samples, order preserved.
REQ-037 Bench SHALL cover: fifo_valid forced to 0 for 3 cycles after beat 4 -> beat counter holds, burst completes with exactly 8 beats.
REQ-038 Bench SHALL cover: reset pulsed after beat 5 -> m_valid=0 and busy=0 asynchronously, burst_count=0; the next full burst is delivered normally.
REQ-039 Bench SHALL cover: 24 words preloaded with m_ready=1 -> 3 back-to-back bursts, burst_count=3, m_last on beats 8, 16 and 24.
